// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Package     : trace_pkg
// Description : Shared definitions for the CPU execution-trace buffer.
//               Holds the FSM state encoding, the trace-record field
//               offsets and the record width helper.
//               Record layout (MSB..LSB): {pc, rf_we, rf_waddr, rf_wdata, dm_we}
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // FSM state encoding; these values are also what state_o presents.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_POST  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Register-file write address width (32 architectural registers).
    localparam int c_WADDR_W = 5;

    // Fixed low-order field offsets.
    localparam int c_OFF_DM_WE = 0;
    localparam int c_OFF_WDATA = 1;

    // Offsets of the fields that sit above the data word.
    function automatic int off_waddr(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int off_rf_we(input int data_w);
        return data_w + 1 + c_WADDR_W;
    endfunction

    function automatic int off_pc(input int data_w);
        return data_w + 2 + c_WADDR_W;
    endfunction

    // Total record width.
    function automatic int rec_w(input int pc_w, input int data_w);
        return pc_w + 1 + c_WADDR_W + data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : trace_ram
// Description : DEPTH x REC_W trace storage. One synchronous write port and
//               one synchronous read port with one cycle of read latency.
//               The read register clears on reset so the readout bus starts
//               at zero; the array itself is never reset.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_we/i_waddr/i_wdata - write port
//               i_re/i_raddr     - read request, data on o_rdata next cycle
//               o_rdata          - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int REC_W = 71
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [REC_W-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [REC_W-1:0]         o_rdata
);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_buffer
// Description : Execution-trace capture unit placed beside the single-cycle
//               CPU. While armed it records {pc, rf_we, rf_waddr, rf_wdata,
//               dm_we} into a circular buffer, freezes POST_CNT records
//               after a PC-match trigger, then replays the frozen trace
//               oldest-first through a pop/valid port.
//               Build option: define TRACE_WRITES_ONLY_EN to record only
//               cycles that write the register file or data memory (the
//               trigger cycle is always recorded).
// Ports       : clk_i, rst_i       - clock, synchronous active-high reset
//               pc_i               - PC of the current instruction
//               rf_we_i/rf_waddr_i/rf_wdata_i - register-file write port
//               dm_we_i            - data-memory write strobe
//               arm_i              - clear buffer and start capture
//               trig_pc_i          - trigger PC
//               rd_en_i            - pop one record (DONE only)
//               rd_data_o/rd_valid_o - popped record, valid one cycle later
//               state_o            - 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//               count_o            - stored record count
//               wrapped_o          - oldest records were overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter  int PC_W     = 32,
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 16,
    parameter  int POST_CNT = 4,
    localparam int REC_W    = rec_w(PC_W, DATA_W),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PC_W-1:0]      pc_i,
    input  logic                 rf_we_i,
    input  logic [c_WADDR_W-1:0] rf_waddr_i,
    input  logic [DATA_W-1:0]    rf_wdata_i,
    input  logic                 dm_we_i,
    input  logic                 arm_i,
    input  logic [PC_W-1:0]      trig_pc_i,
    input  logic                 rd_en_i,
    output logic [REC_W-1:0]     rd_data_o,
    output logic                 rd_valid_o,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 wrapped_o
);

    localparam int               c_AW        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL      = CNT_W'(DEPTH);
    localparam logic [c_AW-1:0]  c_POST_INIT = c_AW'(POST_CNT);
    localparam logic [c_AW-1:0]  c_POST_LAST = c_AW'(1);
    localparam logic             c_NO_POST   = (POST_CNT == 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_wrapped;
    logic [c_AW-1:0]  r_post_cnt;
    logic             r_rd_valid;
    logic             w_capture;
    logic             w_match;
    logic             w_rec;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Next-state and strobe decode. arm_i suppresses both recording and
    // popping so that the arm cycle leaves no trace.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = (r_state == c_ST_ARMED) || (r_state == c_ST_POST);
        // Only ARMED looks for the trigger; matches during POST are ignored.
        w_match     = (r_state == c_ST_ARMED) && (pc_i == trig_pc_i);
`ifdef TRACE_WRITES_ONLY_EN
        w_rec       = w_capture && !arm_i && (rf_we_i || dm_we_i || w_match);
`else
        w_rec       = w_capture && !arm_i;
`endif
        w_pop       = (r_state == c_ST_DONE) && rd_en_i && (r_count != '0) && !arm_i;

        if (arm_i) begin
            w_state_nxt = c_ST_ARMED;
        end else begin
            case (r_state)
                c_ST_IDLE: ;
                c_ST_ARMED: begin
                    if (w_match) begin
                        w_state_nxt = c_NO_POST ? c_ST_DONE : c_ST_POST;
                    end
                end
                c_ST_POST: begin
                    // Last post-trigger record is being written this cycle.
                    if (w_rec && (r_post_cnt == c_POST_LAST)) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_DONE: ;
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and counters. Recording and popping are mutually exclusive
    // by state, so the two rd_ptr updates never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || arm_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_post_cnt <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;

            if (w_rec) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count == c_FULL) begin
                    // Full: the new record displaces the oldest one.
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_wrapped <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            if (w_match) begin
                r_post_cnt <= c_POST_INIT;
            end else if ((r_state == c_ST_POST) && w_rec) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_we    (w_rec),
        .i_waddr (r_wr_ptr),
        .i_wdata ({pc_i, rf_we_i, rf_waddr_i, rf_wdata_i, dm_we_i}),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data_o)
    );

    assign rd_valid_o = r_rd_valid;
    assign state_o    = r_state;
    assign count_o    = r_count;
    assign wrapped_o  = r_wrapped;

endmodule
`default_nettype wire
